// File: rtl/hood_pkg.sv
// Shared definitions for the range-hood mode controller and the display decoder
// that consumes its mode codes.
package hood_pkg;

  localparam int SECS_W = 8;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_STANDBY,
    ST_L1,
    ST_L2,
    ST_STORM,
    ST_CLEAN
  } hood_state_e;

  localparam logic [7:0] MC_OFF        = 8'h00;
  localparam logic [7:0] MC_STANDBY    = 8'h01;
  localparam logic [7:0] MC_L1         = 8'h02;
  localparam logic [7:0] MC_L2         = 8'h03;
  localparam logic [7:0] MC_STORM      = 8'h04;
  localparam logic [7:0] MC_CLEAN_BASE = 8'h10;

  // Buttons ranked so that a larger value wins when pulses coincide.
  typedef enum logic [2:0] {
    BTN_NONE,
    BTN_L1,
    BTN_L2,
    BTN_L3,
    BTN_CLEAN,
    BTN_POWER
  } btn_e;

  function automatic btn_e pick_btn(input logic power, input logic clean,
                                    input logic l3, input logic l2,
                                    input logic l1);
    if (power)      return BTN_POWER;
    else if (clean) return BTN_CLEAN;
    else if (l3)    return BTN_L3;
    else if (l2)    return BTN_L2;
    else if (l1)    return BTN_L1;
    else            return BTN_NONE;
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides the system clock down to a one-cycle pulse once per second.
// Clearing restarts the second so a freshly entered state gets a full one.
module sec_prescaler #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hood_mode_ctrl.sv
// Range-hood operating-mode FSM with storm and self-clean countdowns; all
// outputs are registered from the next-state logic.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int STORM_SECS = 60,
  parameter int CLEAN_SECS = 180
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_power,
  input  logic              btn_l1,
  input  logic              btn_l2,
  input  logic              btn_l3,
  input  logic              btn_clean,
  output logic [7:0]        mode_code,
  output logic [SECS_W-1:0] secs_left,
  output logic              storm_used,
  output logic              clean_done
);

  localparam logic [SECS_W-1:0] STORM_LOAD = SECS_W'(STORM_SECS);
  localparam logic [SECS_W-1:0] CLEAN_LOAD = SECS_W'(CLEAN_SECS);
  localparam logic [SECS_W-1:0] ONE        = SECS_W'(1);

  // Phase k begins once elapsed*4 >= k*CLEAN_SECS, i.e. elapsed >= ceil(k*CLEAN_SECS/4).
  localparam int Q1 = (CLEAN_SECS + 3) / 4;
  localparam int Q2 = (2 * CLEAN_SECS + 3) / 4;
  localparam int Q3 = (3 * CLEAN_SECS + 3) / 4;
  localparam logic [SECS_W-1:0] SECS_Q1 = SECS_W'(CLEAN_SECS - Q1);
  localparam logic [SECS_W-1:0] SECS_Q2 = SECS_W'(CLEAN_SECS - Q2);
  localparam logic [SECS_W-1:0] SECS_Q3 = SECS_W'(CLEAN_SECS - Q3);

  hood_state_e       state_q, state_d;
  logic [SECS_W-1:0] secs_d;
  logic              storm_d;
  logic              done_d;
  logic [7:0]        mode_d;
  logic              tick;
  logic              presc_clear;
  btn_e              btn;

  assign btn         = pick_btn(btn_power, btn_clean, btn_l3, btn_l2, btn_l1);
  assign presc_clear = (state_d != state_q);

  sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(presc_clear),
    .tick (tick)
  );

  function automatic logic [7:0] clean_code(input logic [SECS_W-1:0] secs);
    if (secs <= SECS_Q3)      return MC_CLEAN_BASE + 8'd3;
    else if (secs <= SECS_Q2) return MC_CLEAN_BASE + 8'd2;
    else if (secs <= SECS_Q1) return MC_CLEAN_BASE + 8'd1;
    else                      return MC_CLEAN_BASE;
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    secs_d  = secs_left;
    storm_d = storm_used;
    done_d  = 1'b0;

    case (state_q)
      ST_OFF: begin
        if (btn == BTN_POWER) begin
          state_d = ST_STANDBY;
          storm_d = 1'b0;
        end
      end

      ST_STANDBY, ST_L1, ST_L2: begin
        case (btn)
          BTN_POWER: state_d = ST_OFF;
          BTN_CLEAN: begin
            if (state_q == ST_STANDBY) begin
              state_d = ST_CLEAN;
              secs_d  = CLEAN_LOAD;
            end
          end
          BTN_L3: begin
            if (!storm_used) begin
              state_d = ST_STORM;
              secs_d  = STORM_LOAD;
              storm_d = 1'b1;
            end
          end
          BTN_L2:  state_d = ST_L2;
          BTN_L1:  state_d = ST_L1;
          default: ;
        endcase
      end

      // A taken button overrides a coincident expiry tick.
      ST_STORM: begin
        case (btn)
          BTN_POWER: begin state_d = ST_OFF; secs_d = '0; end
          BTN_L2:    begin state_d = ST_L2;  secs_d = '0; end
          BTN_L1:    begin state_d = ST_L1;  secs_d = '0; end
          default: begin
            if (tick) begin
              if (secs_left == ONE) begin
                state_d = ST_L2;
                secs_d  = '0;
              end else begin
                secs_d = secs_left - ONE;
              end
            end
          end
        endcase
      end

      ST_CLEAN: begin
        if (btn == BTN_POWER) begin
          state_d = ST_OFF;
          secs_d  = '0;
        end else if (tick) begin
          if (secs_left == ONE) begin
            state_d = ST_STANDBY;
            secs_d  = '0;
            done_d  = 1'b1;
          end else begin
            secs_d = secs_left - ONE;
          end
        end
      end

      default: begin
        state_d = ST_OFF;
        secs_d  = '0;
      end
    endcase
  end

  always_comb begin
    mode_d = MC_OFF;
    case (state_d)
      ST_STANDBY: mode_d = MC_STANDBY;
      ST_L1:      mode_d = MC_L1;
      ST_L2:      mode_d = MC_L2;
      ST_STORM:   mode_d = MC_STORM;
      ST_CLEAN:   mode_d = clean_code(secs_d);
      default:    mode_d = MC_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      mode_code  <= MC_OFF;
      secs_left  <= '0;
      storm_used <= 1'b0;
      clean_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_code  <= mode_d;
      secs_left  <= secs_d;
      storm_used <= storm_d;
      clean_done <= done_d;
    end
  end

endmodule
